// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory handshake FSM, branch resolution and MEM/WB register.
// Optional access-timeout logic is enabled with `define MEM_TIMEOUT_EN.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_branch_MEM,
  input  logic [31:0] alu_MEM,
  input  logic [31:0] writedata_MEM,
  input  logic [4:0]  rd_MEM,
  input  logic        zero_MEM,
  input  logic        branch_MEM,
  input  logic        memread_MEM,
  input  logic        memwrite_MEM,
  input  logic        memtoreg_MEM,
  input  logic        regwrite_MEM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall_mem,
  output logic        pc_src,
  output logic [31:0] pc_target,
  output logic        flush_req,
  output logic [31:0] readdata_WB,
  output logic [31:0] alu_WB,
  output logic [4:0]  rd_WB,
  output logic        memtoreg_WB,
  output logic        regwrite_WB,
  output logic        mem_err
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t state, state_next;
  logic   memop;
  logic   timeout;
  logic   start;

  assign memop = memread_MEM | memwrite_MEM;
  assign start = (state == IDLE) && memop;

`ifdef MEM_TIMEOUT_EN
  logic [3:0] wait_cnt;

  // Timeout fires in the ACCESS cycle whose un-acked edge would bring the counter to 15.
  assign timeout = (state == ACCESS) && !dmem_ack && (wait_cnt == 4'd14);

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= 4'd0;
    end else if (start) begin
      wait_cnt <= 4'd0;
    end else if ((state == ACCESS) && !dmem_ack) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_err <= 1'b0;
    end else begin
      mem_err <= timeout;
    end
  end
`else
  assign timeout = 1'b0;
  assign mem_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    stall_mem  = 1'b0;
    case (state)
      IDLE: begin
        if (memop) begin
          state_next = ACCESS;
          stall_mem  = 1'b1;
        end
      end
      ACCESS: begin
        if (dmem_ack || timeout) begin
          state_next = IDLE;
        end else begin
          stall_mem = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request attributes are latched on entry so the memory sees them stable for the whole access.
  always_ff @(posedge clk) begin
    if (reset) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_wdata <= 32'd0;
    end else begin
      dmem_req <= (state_next == ACCESS);
      if (start) begin
        dmem_we    <= memwrite_MEM & ~memread_MEM;
        dmem_addr  <= alu_MEM;
        dmem_wdata <= writedata_MEM;
      end
    end
  end

  assign pc_src    = branch_MEM & zero_MEM;
  assign pc_target = pc_branch_MEM;
  assign flush_req = pc_src & ~stall_mem;

  // A stalled edge sends a bubble to WB; an unstalled edge retires the instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata_WB <= 32'd0;
      alu_WB      <= 32'd0;
      rd_WB       <= 5'd0;
      memtoreg_WB <= 1'b0;
      regwrite_WB <= 1'b0;
    end else if (!stall_mem) begin
      alu_WB      <= alu_MEM;
      rd_WB       <= rd_MEM;
      memtoreg_WB <= memtoreg_MEM;
      regwrite_WB <= regwrite_MEM & (rd_MEM != 5'd0) & ~timeout;
      if (timeout) begin
        readdata_WB <= 32'hDEADBEEF;
      end else if ((state == ACCESS) && dmem_ack && memread_MEM) begin
        readdata_WB <= dmem_rdata;
      end
    end else begin
      regwrite_WB <= 1'b0;
      memtoreg_WB <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized traffic
// checked against a transaction-level expectation model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_branch_MEM, alu_MEM, writedata_MEM;
  logic [4:0]  rd_MEM;
  logic        zero_MEM, branch_MEM, memread_MEM, memwrite_MEM, memtoreg_MEM, regwrite_MEM;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        stall_mem, pc_src, flush_req;
  logic [31:0] pc_target, readdata_WB, alu_WB;
  logic [4:0]  rd_WB;
  logic        memtoreg_WB, regwrite_WB, mem_err;

  int          checks_total  = 0;
  int          checks_passed = 0;
  logic [31:0] exp_readdata  = 32'd0;

  mem_stage dut (
    .clk(clk), .reset(reset),
    .pc_branch_MEM(pc_branch_MEM), .alu_MEM(alu_MEM), .writedata_MEM(writedata_MEM),
    .rd_MEM(rd_MEM), .zero_MEM(zero_MEM), .branch_MEM(branch_MEM),
    .memread_MEM(memread_MEM), .memwrite_MEM(memwrite_MEM),
    .memtoreg_MEM(memtoreg_MEM), .regwrite_MEM(regwrite_MEM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall_mem(stall_mem), .pc_src(pc_src), .pc_target(pc_target), .flush_req(flush_req),
    .readdata_WB(readdata_WB), .alu_WB(alu_WB), .rd_WB(rd_WB),
    .memtoreg_WB(memtoreg_WB), .regwrite_WB(regwrite_WB), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  // Tasks are entered and left just after a falling edge; inputs change only there.
  task automatic drive_nop();
    pc_branch_MEM = 32'd0; alu_MEM = 32'd0; writedata_MEM = 32'd0; rd_MEM = 5'd0;
    zero_MEM = 1'b0; branch_MEM = 1'b0; memread_MEM = 1'b0; memwrite_MEM = 1'b0;
    memtoreg_MEM = 1'b0; regwrite_MEM = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'd0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got !== exp) $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    else checks_passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_nop();
    @(negedge clk); #1;
    chk("reset dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("reset dmem_we", {31'd0, dmem_we}, 32'd0);
    chk("reset dmem_addr", dmem_addr, 32'd0);
    chk("reset dmem_wdata", dmem_wdata, 32'd0);
    chk("reset readdata_WB", readdata_WB, 32'd0);
    chk("reset alu_WB", alu_WB, 32'd0);
    chk("reset rd_WB", {27'd0, rd_WB}, 32'd0);
    chk("reset wb ctrl", {30'd0, memtoreg_WB, regwrite_WB}, 32'd0);
    chk("reset mem_err", {31'd0, mem_err}, 32'd0);
    chk("reset stall_mem", {31'd0, stall_mem}, 32'd0);
    reset = 1'b0;
    exp_readdata = 32'd0;
  endtask

  task automatic test_alu(input logic [31:0] alu, input logic [4:0] rd, input logic rw,
                          input logic mtr, input logic br, input logic zr, input logic [31:0] pcb);
    logic take;
    take = br & zr;
    drive_nop();
    alu_MEM = alu; rd_MEM = rd; regwrite_MEM = rw; memtoreg_MEM = mtr;
    branch_MEM = br; zero_MEM = zr; pc_branch_MEM = pcb;
    #1;
    chk("alu stall_mem", {31'd0, stall_mem}, 32'd0);
    chk("alu pc_src", {31'd0, pc_src}, {31'd0, take});
    chk("alu pc_target", pc_target, pcb);
    chk("alu flush_req", {31'd0, flush_req}, {31'd0, take});
    chk("alu dmem_req", {31'd0, dmem_req}, 32'd0);
    @(negedge clk); #1;
    chk("alu alu_WB", alu_WB, alu);
    chk("alu rd_WB", {27'd0, rd_WB}, {27'd0, rd});
    chk("alu regwrite_WB", {31'd0, regwrite_WB}, {31'd0, rw && (rd != 5'd0)});
    chk("alu memtoreg_WB", {31'd0, memtoreg_WB}, {31'd0, mtr});
    chk("alu readdata_WB hold", readdata_WB, exp_readdata);
  endtask

  // One memory instruction; the responder acks after `waitc` extra request cycles.
  task automatic test_access(input logic rdb, input logic wrb, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input logic [4:0] rd, input logic rw, input logic mtr,
                             input int waitc, input logic early_ack);
    int   stalls = 0;
    int   reqc = 0;
    bit   hold_ok = 1'b1;
    bit   bubble_ok = 1'b1;
    bit   is_load;
    logic exp_we;
    is_load = rdb;
    exp_we  = wrb & ~rdb;
    drive_nop();
    memread_MEM = rdb; memwrite_MEM = wrb; rd_MEM = rd; regwrite_MEM = rw; memtoreg_MEM = mtr;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (dmem_req === 1'b1) reqc++;
      dmem_ack   = (dmem_req === 1'b1) ? (reqc == waitc + 1) : early_ack;
      dmem_rdata = (dmem_req === 1'b1 && dmem_ack) ? rdata : $urandom;
      if (dmem_req === 1'b1 && !dmem_ack) begin
        alu_MEM = $urandom; writedata_MEM = $urandom;
      end else begin
        alu_MEM = addr; writedata_MEM = wdata;
      end
      #1;
      if (dmem_req === 1'b1 &&
          (dmem_we !== exp_we || dmem_addr !== addr || dmem_wdata !== wdata)) hold_ok = 1'b0;
      if (cyc >= 1 && (regwrite_WB !== 1'b0 || memtoreg_WB !== 1'b0)) bubble_ok = 1'b0;
      if (stall_mem !== 1'b1) break;
      stalls++;
    end
    @(negedge clk);
    dmem_ack = 1'b0;
    if (is_load) exp_readdata = rdata;
    #1;
    chk("mem stall cycles", stalls, waitc + 1);
    chk("mem request hold", {31'd0, hold_ok}, 32'd1);
    chk("mem bubble", {31'd0, bubble_ok}, 32'd1);
    chk("mem req drop", {31'd0, dmem_req}, 32'd0);
    chk("mem readdata_WB", readdata_WB, exp_readdata);
    chk("mem alu_WB", alu_WB, addr);
    chk("mem rd_WB", {27'd0, rd_WB}, {27'd0, rd});
    chk("mem regwrite_WB", {31'd0, regwrite_WB}, {31'd0, rw && (rd != 5'd0)});
    chk("mem memtoreg_WB", {31'd0, memtoreg_WB}, {31'd0, mtr});
  endtask

  task automatic test_branch_stall();
    drive_nop();
    memread_MEM = 1'b1; alu_MEM = 32'h44; branch_MEM = 1'b1; zero_MEM = 1'b1;
    pc_branch_MEM = 32'h1234;
    #1;
    chk("branch stall pc_src", {31'd0, pc_src}, 32'd1);
    chk("branch stall flush_req", {31'd0, flush_req}, 32'd0);
    test_reset();
  endtask

  task automatic test_reset_in_access(input logic same_edge_ack);
    drive_nop();
    memread_MEM = 1'b1; alu_MEM = 32'h200; rd_MEM = 5'd7; regwrite_MEM = 1'b1; memtoreg_MEM = 1'b1;
    @(negedge clk); #1;
    chk("rst-access dmem_req", {31'd0, dmem_req}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    dmem_ack = same_edge_ack; dmem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    reset = 1'b0;
    drive_nop();
    exp_readdata = 32'd0;
    #1;
    chk("rst-access req off", {31'd0, dmem_req}, 32'd0);
    chk("rst-access regwrite_WB", {31'd0, regwrite_WB}, 32'd0);
    chk("rst-access readdata_WB", readdata_WB, 32'd0);
    chk("rst-access rd_WB", {27'd0, rd_WB}, 32'd0);
    @(negedge clk); #1;
    dmem_ack = 1'b1; dmem_rdata = 32'h0BADF00D;
    #1;
    chk("late ack stall", {31'd0, stall_mem}, 32'd0);
    @(negedge clk);
    dmem_ack = 1'b0;
    #1;
    chk("late ack readdata_WB", readdata_WB, 32'd0);
    chk("late ack dmem_req", {31'd0, dmem_req}, 32'd0);
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    int stalls = 0;
    drive_nop();
    memread_MEM = 1'b1; alu_MEM = 32'h300; rd_MEM = 5'd9; regwrite_MEM = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc > 0) @(negedge clk);
      #1;
      if (stall_mem !== 1'b1) break;
      stalls++;
    end
    @(negedge clk);
    drive_nop();
    exp_readdata = 32'hDEADBEEF;
    #1;
    chk("timeout stall cycles", stalls, 15);
    chk("timeout mem_err", {31'd0, mem_err}, 32'd1);
    chk("timeout readdata_WB", readdata_WB, 32'hDEADBEEF);
    chk("timeout regwrite_WB", {31'd0, regwrite_WB}, 32'd0);
    chk("timeout dmem_req", {31'd0, dmem_req}, 32'd0);
    @(negedge clk); #1;
    chk("timeout mem_err pulse", {31'd0, mem_err}, 32'd0);
  endtask
`endif

  task automatic test_random();
    int op;
    for (int i = 0; i < 24; i++) begin
      op = int'($urandom_range(0, 3));
      if (op == 0)
        test_alu($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom);
      else
        test_access(op != 2, op != 1, $urandom, $urandom, $urandom,
                    5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
                    1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        drive_nop();
        @(negedge clk); #1;
      end
    end
  endtask

  task automatic test_back_to_back();
    test_access(1'b1, 1'b0, 32'h500, 32'h0, 32'h11112222, 5'd3, 1'b1, 1'b1, 0, 1'b0);
    test_access(1'b0, 1'b1, 32'h504, 32'h33334444, 32'h0, 5'd4, 1'b0, 1'b0, 2, 1'b0);
    test_access(1'b1, 1'b0, 32'h508, 32'h0, 32'h55556666, 5'd6, 1'b1, 1'b1, 1, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    drive_nop();
    @(negedge clk);
    test_reset();
    test_access(1'b1, 1'b0, 32'h100, 32'h0, 32'h12345678, 5'd5, 1'b1, 1'b1, 1, 1'b0);
    test_access(1'b0, 1'b1, 32'h40, 32'hA5A5A5A5, 32'hFFFFFFFF, 5'd2, 1'b0, 1'b0, 3, 1'b0);
    test_alu(32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h80);
    test_alu(32'h77, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    test_access(1'b1, 1'b1, 32'h60, 32'h9999, 32'h87654321, 5'd8, 1'b1, 1'b0, 0, 1'b1);
    test_branch_stall();
    test_reset_in_access(1'b0);
    test_reset_in_access(1'b1);
    test_back_to_back();
    test_random();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: clk input 1, rising-edge clock; reset input 1, synchronous, active-high.
REQ-002 SHALL have EX/MEM-side inputs: pc_branch_MEM input 32, branch target; alu_MEM input 32, address/result; writedata_MEM input 32, store data; rd_MEM input 5, dest reg; zero_MEM input 1; branch_MEM, memread_MEM, memwrite_MEM, memtoreg_MEM, regwrite_MEM input 1 each, control bits.
REQ-003 SHALL have memory-side ports: dmem_req output 1, request; dmem_we output 1, 1 = store; dmem_addr output 32; dmem_wdata output 32; dmem_ack input 1, single-cycle completion; dmem_rdata input 32, valid when dmem_ack=1.
REQ-004 SHALL have pipeline-control outputs: stall_mem output 1, hold EX/MEM and earlier stages; pc_src output 1, take branch; pc_target output 32; flush_req output 1, flush IF/ID, ID/EX and EX/MEM.
REQ-005 SHALL have MEM/WB outputs, all registered: readdata_WB output 32; alu_WB output 32; rd_WB output 5; memtoreg_WB output 1; regwrite_WB output 1; mem_err output 1, access-timeout pulse.

Function
REQ-006 SHALL define memop = memread_MEM | memwrite_MEM; if both are set, SHALL treat the access as a load.
REQ-007 SHALL implement a 2-state FSM with states IDLE and ACCESS.
REQ-008 IDLE->ACCESS SHALL occur on the first edge with memop=1; ACCESS->IDLE SHALL occur on the edge where dmem_ack=1.
REQ-009 dmem_req SHALL be registered: 1 throughout ACCESS, 0 in IDLE.
REQ-010 dmem_we, dmem_addr=alu_MEM and dmem_wdata=writedata_MEM SHALL be captured on IDLE->ACCESS and held stable while dmem_req=1.
REQ-011 stall_mem SHALL be combinational: (IDLE & memop) | (ACCESS & ~dmem_ack).
REQ-012 Minimum memop occupancy SHALL be 2 cycles (ack in the first ACCESS cycle); each extra ack-wait cycle SHALL add one stall cycle.
REQ-013 When stall_mem=0, the next edge SHALL load the MEM/WB registers:
- readdata_WB = dmem_rdata for a load, else hold;
- alu_WB, rd_WB, memtoreg_WB copied from the EX/MEM inputs;
- regwrite_WB = regwrite_MEM & (rd_MEM != 0).
REQ-014 When stall_mem=1, each edge SHALL insert a bubble: regwrite_WB=0 and memtoreg_WB=0; other WB fields hold.
REQ-015 dmem_ack while in IDLE SHALL be ignored.
REQ-016 pc_src SHALL be combinational: branch_MEM & zero_MEM; pc_target = pc_branch_MEM.
REQ-017 flush_req SHALL equal pc_src & ~stall_mem.
REQ-018 Back-to-back memops SHALL each re-enter ACCESS through one IDLE stall cycle; no request overlap.
REQ-019 mem_err SHALL be 0 except as given in REQ-025.

Reset
REQ-020 Reset SHALL force, on the next edge:
- state IDLE;
- dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0;
- all WB outputs 0, mem_err=0.
REQ-021 Reset in ACCESS SHALL abandon the access with no WB update; a later dmem_ack SHALL be ignored.
REQ-022 Reset SHALL take priority over dmem_ack and all other inputs on the same edge.

Configuration
REQ-023 Macro MEM_TIMEOUT_EN SHALL select access-timeout logic.
REQ-024 Defined: a 4-bit counter SHALL clear on IDLE->ACCESS and increment each ACCESS cycle without ack.
REQ-025 Defined, counter reaching 15 without ack:
- on that edge: return to IDLE, dmem_req=0, pulse mem_err high for 1 cycle;
- stall_mem SHALL be 0 in that cycle, and the WB load on that edge SHALL set readdata_WB=32'hDEADBEEF and regwrite_WB=0.
REQ-026 Undefined: no counter; ACCESS SHALL wait indefinitely; mem_err SHALL be tied 0.

Verification
REQ-027 Load, alu_MEM=0x100, rd=5, ack 1 cycle after req, rdata=0x12345678 -> stall_mem high for 2 cycles; then readdata_WB=0x12345678, rd_WB=5, regwrite_WB=1.
REQ-028 Store, alu=0x40, wdata=0xA5A5A5A5, ack after 3 cycles -> dmem_we=1 with addr/wdata stable throughout; stall for 4 cycles; regwrite_WB=0.
REQ-029 Branch, zero_MEM=1, pc_branch=0x80 -> pc_src=1, pc_target=0x80, flush_req=1 in the same cycle; no dmem_req.
REQ-030 ALU op, regwrite=1, rd=0 -> regwrite_WB=0; reset asserted during ACCESS -> dmem_req=0 next cycle; ack 2 cycles later ignored.
REQ-031 MEM_TIMEOUT_EN defined, load with no ack -> mem_err pulses after 15 ACCESS cycles; readdata_WB=0xDEADBEEF; regwrite_WB=0; stall_mem released.
